// File: rtl/mips_mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences each instruction through fetch, decode,
// execute, memory and write-back, with memory handshake, watchdog, trap and retire counter.
package mips_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } ALU_ctrl_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    ALU_ctrl_e  alu_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

module mips_mc_ctrl_fsm
  import mips_mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 en_pc,
  output logic [1:0]           PCSrc,
  output logic                 ALUSrcA,
  output logic [2:0]           ALUSrcB,
  output ALU_ctrl_e            ALUControl,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 instr_retired,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // wait_cnt never needs to hold more than TIMEOUT_CYCLES-1
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    EXECI  = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    ERROR  = 4'd12
  } state_e;

  function automatic logic legal_funct(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction

  function automatic ALU_ctrl_e alu_from_funct(input logic [5:0] f);
    case (f)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Control word for a state; anything a state does not drive stays 0
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] op_i,
                                        input logic [5:0] funct_i);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 3'b001; c.alu_control = ALU_ADD; end
      DECODE: begin c.alu_src_b = 3'b100; c.alu_control = ALU_ADD; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 3'b010; c.alu_control = ALU_ADD; end
      MEMRD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_control = alu_from_funct(funct_i); end
      EXECI: begin
        c.alu_src_a = 1'b1;
        case (op_i)
          OP_ANDI: begin c.alu_src_b = 3'b011; c.alu_control = ALU_AND; end
          OP_ORI:  begin c.alu_src_b = 3'b011; c.alu_control = ALU_OR;  end
          default: begin c.alu_src_b = 3'b010; c.alu_control = ALU_ADD; end
        endcase
      end
      ALUWB:  begin c.reg_dst = (op_i == OP_RTYPE); c.reg_write = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_src = 2'b01; end
      JUMP:   begin c.pc_src = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e                 state_r;
  state_e                 next_state_s;
  ctrl_t                  ctrl_r;
  logic                   bne_r;
  logic [WAIT_W-1:0]      wait_cnt_r;
  logic [CNT_WIDTH-1:0]   retired_count_r;
  logic                   error_r;
  logic [1:0]             err_code_r;
  logic [1:0]             err_next_s;
  logic                   wait_state_s;
  logic                   timeout_s;
  logic                   retire_s;

  // Watchdog expiry and retire strobe
  always_comb begin
    wait_state_s = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
    timeout_s    = (TIMEOUT_CYCLES > 0) && wait_state_s && !mem_ready &&
                   (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1));
    retire_s     = (state_r == MEMWB) || (state_r == ALUWB) || (state_r == BRANCH) ||
                   (state_r == JUMP) || ((state_r == MEMWR) && mem_ready);
  end

  // Next-state and trap-cause selection
  always_comb begin
    next_state_s = state_r;
    err_next_s   = ERR_NONE;
    case (state_r)
      IDLE:   next_state_s = FETCH;
      FETCH, MEMRD, MEMWR: begin
        if (mem_ready) begin
          next_state_s = (state_r == FETCH) ? DECODE : ((state_r == MEMRD) ? MEMWB : FETCH);
        end else if (timeout_s) begin
          next_state_s = ERROR;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          next_state_s = state_r;
        end
      end
      DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) begin
          next_state_s = MEMADR;
        end else if ((op == OP_RTYPE) && legal_funct(funct)) begin
          next_state_s = EXEC;
        end else if ((op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI)) begin
          next_state_s = EXECI;
        end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
          next_state_s = BRANCH;
        end else if (op == OP_J) begin
          next_state_s = JUMP;
        end else begin
          next_state_s = ERROR;
          err_next_s   = ERR_ILLEGAL;
        end
      end
      MEMADR: next_state_s = (op == OP_LW) ? MEMRD : MEMWR;
      EXEC, EXECI: next_state_s = ALUWB;
      MEMWB, ALUWB, BRANCH, JUMP: next_state_s = FETCH;
      ERROR:  next_state_s = ERROR;
      default: next_state_s = IDLE;
    endcase
  end

  // State, control word registered from the next state, watchdog, retire count, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      ctrl_r          <= '0;
      bne_r           <= 1'b0;
      wait_cnt_r      <= '0;
      retired_count_r <= '0;
      error_r         <= 1'b0;
      err_code_r      <= ERR_NONE;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s, op, funct);
      bne_r   <= (op == OP_BNE);
      if ((TIMEOUT_CYCLES == 0) || mem_ready || (next_state_s != state_r)) begin
        wait_cnt_r <= '0;
      end else if (wait_state_s) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (retire_s) begin
        retired_count_r <= retired_count_r + CNT_WIDTH'(1);
      end
      if ((next_state_s == ERROR) && (state_r != ERROR)) begin
        error_r    <= 1'b1;
        err_code_r <= err_next_s;
      end
    end
  end

  assign mem_req       = ctrl_r.mem_req;
  assign IorD          = ctrl_r.iord;
  assign MemWrite      = ctrl_r.mem_write;
  assign PCSrc         = ctrl_r.pc_src;
  assign ALUSrcA       = ctrl_r.alu_src_a;
  assign ALUSrcB       = ctrl_r.alu_src_b;
  assign ALUControl    = ctrl_r.alu_control;
  assign RegDst        = ctrl_r.reg_dst;
  assign MemtoReg      = ctrl_r.mem_to_reg;
  assign RegWrite      = ctrl_r.reg_write;
  // Strobes that must react to the handshake or the branch condition in the same cycle
  assign IRWrite       = (state_r == FETCH) && mem_ready;
  assign en_pc         = ((state_r == FETCH) && mem_ready) ||
                         ((state_r == BRANCH) && (zero ^ bne_r)) || (state_r == JUMP);
  assign instr_retired = retire_s;
  assign retired_count = retired_count_r;
  assign error         = error_r;
  assign err_code      = err_code_r;

endmodule
